// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: hazard encodings, NOP word and FSM state encodings.
package fetch_unit_pkg;

  localparam logic [3:0] HS_DN       = 4'd0;
  localparam logic [3:0] FLUSH_ALL   = 4'd1;
  localparam logic [3:0] FLUSH_EARLY = 4'd2;
  localparam logic [3:0] STALL_MMU   = 4'd3;
  localparam logic [3:0] STALL_EARLY = 4'd4;

  localparam logic [31:0] NOP_INST_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_t;

  function automatic logic is_flush(input logic [3:0] hs);
    return (hs == FLUSH_ALL) || (hs == FLUSH_EARLY);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// One-entry holding buffer for an IMEM response that arrived while decode was stalled.
module fetch_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_inst,
  input  logic [31:0] wr_pc,
  input  logic        rd_en,
  input  logic        clr,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] pc
);

  logic        valid_reg;
  logic [31:0] inst_reg;
  logic [31:0] pc_reg;

  // Clear wins over write, write wins over read.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      inst_reg  <= 32'h0;
      pc_reg    <= 32'h0;
    end else if (clr) begin
      valid_reg <= 1'b0;
    end else if (wr_en) begin
      valid_reg <= 1'b1;
      inst_reg  <= wr_inst;
      pc_reg    <= wr_pc;
    end else if (rd_en) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign inst  = inst_reg;
  assign pc    = pc_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, single-outstanding IMEM handshake,
// one-entry response buffer and the IF/ID pipeline register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  hazard_signal,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] jump_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        stall_IMEM,
  output logic [31:0] IFpc,
  output logic [31:0] IFinst,
  output logic        IFvalid,
  output logic [4:0]  IFrs1,
  output logic [4:0]  IFrs2
);

  fetch_state_t state_reg;
  logic [31:0]  fetch_pc_reg;
  logic         drop_reg;

  logic         flush;
  logic         advance;
  logic [31:0]  flush_target;
  logic         live_rsp;
  logic         buf_valid;
  logic [31:0]  buf_inst;
  logic [31:0]  buf_pc;
  logic         buf_wr;
  logic         buf_rd;

  assign flush        = is_flush(hazard_signal);
  assign advance      = (hazard_signal == HS_DN);
  assign flush_target = (hazard_signal == FLUSH_ALL) ? redirect_pc : jump_pc;
  assign live_rsp     = (state_reg == ST_WAIT) && imem_rvalid && !drop_reg;

  // Depends only on local state and memory inputs, keeping the hazard unit loop-free.
  assign stall_IMEM = !buf_valid && !live_rsp;

  // The buffer is only ever occupied while idle, so write and read never collide.
  assign buf_wr = !flush && !advance && live_rsp;
  assign buf_rd = !flush && advance && buf_valid;

  fetch_buffer u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (buf_wr),
    .wr_inst (imem_rdata),
    .wr_pc   (imem_addr),
    .rd_en   (buf_rd),
    .clr     (flush),
    .valid   (buf_valid),
    .inst    (buf_inst),
    .pc      (buf_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      fetch_pc_reg <= RESET_PC;
      drop_reg     <= 1'b0;
      imem_req     <= 1'b0;
      imem_addr    <= 32'h0;
      IFvalid      <= 1'b0;
      IFinst       <= NOP_INST;
      IFpc         <= 32'h0;
    end else if (flush) begin
      fetch_pc_reg <= flush_target;
      IFvalid      <= 1'b0;
      IFinst       <= NOP_INST;
      case (state_reg)
        ST_IDLE: begin
          state_reg <= ST_REQ;
          imem_req  <= 1'b1;
          imem_addr <= flush_target;
        end
        ST_REQ: begin
          // The pending request cannot be withdrawn; mark it stale instead.
          drop_reg <= 1'b1;
          if (imem_ready) begin
            state_reg <= ST_WAIT;
            imem_req  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            drop_reg  <= 1'b0;
            state_reg <= ST_REQ;
            imem_req  <= 1'b1;
            imem_addr <= flush_target;
          end else begin
            drop_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end else begin
      if (advance) begin
        if (buf_valid) begin
          IFinst  <= buf_inst;
          IFpc    <= buf_pc;
          IFvalid <= 1'b1;
        end else if (live_rsp) begin
          IFinst  <= imem_rdata;
          IFpc    <= imem_addr;
          IFvalid <= 1'b1;
        end else begin
          IFvalid <= 1'b0;
        end
      end
      case (state_reg)
        ST_IDLE: begin
          if (!buf_valid || buf_rd) begin
            state_reg <= ST_REQ;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc_reg;
          end
        end
        ST_REQ: begin
          if (imem_ready) begin
            state_reg <= ST_WAIT;
            imem_req  <= 1'b0;
            if (!drop_reg) fetch_pc_reg <= imem_addr + 32'd4;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (drop_reg || advance) begin
              drop_reg  <= 1'b0;
              state_reg <= ST_REQ;
              imem_req  <= 1'b1;
              imem_addr <= fetch_pc_reg;
            end else begin
              state_reg <= ST_IDLE;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign IFrs1 = IFinst[19:15];
  assign IFrs2 = IFinst[24:20];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized hazards and memory timing,
// checked against a transaction-level model of the fetch stream.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  hazard_signal = HS_DN;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] jump_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_IMEM;
  logic [31:0] IFpc;
  logic [31:0] IFinst;
  logic        IFvalid;
  logic [4:0]  IFrs1;
  logic [4:0]  IFrs2;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(RPC), .NOP_INST(NOP_INST_WORD)) dut (
    .clk           (clk),
    .rst           (rst),
    .hazard_signal (hazard_signal),
    .redirect_pc   (redirect_pc),
    .jump_pc       (jump_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .stall_IMEM    (stall_IMEM),
    .IFpc          (IFpc),
    .IFinst        (IFinst),
    .IFvalid       (IFvalid),
    .IFrs1         (IFrs1),
    .IFrs2         (IFrs2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Memory: one response per accepted request, lat cycles after acceptance.
  int          lat = 1;
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;

  assign imem_rvalid = mem_pend && (mem_cnt == 0);
  assign imem_rdata  = word_at(mem_addr);

  always @(posedge clk) begin
    if (rst) begin
      mem_pend <= 1'b0;
      mem_cnt  <= 0;
      mem_addr <= 32'h0;
    end else if (imem_rvalid) begin
      mem_pend <= 1'b0;
    end else if (mem_pend) begin
      mem_cnt <= mem_cnt - 1;
    end else if (imem_req && imem_ready) begin
      mem_pend <= 1'b1;
      mem_cnt  <= lat - 1;
      mem_addr <= imem_addr;
    end
  end

  // Reference model: program-order PC stream, stale-request tracking and a one-deep buffer.
  logic        m_valid = 1'b0;
  logic [31:0] m_inst = NOP_INST_WORD;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_next = RPC;
  logic        m_buf = 1'b0;
  logic        m_stale = 1'b0;
  logic        m_live = 1'b0;
  logic        m_avail = 1'b0;
  logic        req_q = 1'b0;
  logic        pend_q = 1'b0;
  logic [31:0] addr_q = 32'h0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_inst  = NOP_INST_WORD;
      m_pc    = 32'h0;
      m_next  = RPC;
      m_buf   = 1'b0;
      m_stale = 1'b0;
    end else begin
      if (req_q && !imem_ready) begin
        chk1("req_held", imem_req, 1'b1);
        chk("addr_held", imem_addr, addr_q);
      end
      if (hazard_signal == FLUSH_ALL || hazard_signal == FLUSH_EARLY) begin
        m_valid = 1'b0;
        m_inst  = NOP_INST_WORD;
        m_buf   = 1'b0;
        if (req_q || pend_q) m_stale = 1'b1;
        m_next  = (hazard_signal == FLUSH_ALL) ? redirect_pc : jump_pc;
      end else if (hazard_signal == HS_DN) begin
        if (m_avail) begin
          m_valid = 1'b1;
          m_pc    = m_next;
          m_inst  = word_at(m_next);
          m_next  = m_next + 32'd4;
          m_buf   = 1'b0;
        end else begin
          m_valid = 1'b0;
        end
      end else if (m_live) begin
        m_buf = 1'b1;
      end
      if (!req_q && imem_req) m_stale = 1'b0;
      chk1("m_IFvalid", IFvalid, m_valid);
      chk("m_IFpc", IFpc, m_pc);
      chk("m_IFinst", IFinst, m_inst);
      chk("m_IFrs1", {27'b0, IFrs1}, {27'b0, m_inst[19:15]});
      chk("m_IFrs2", {27'b0, IFrs2}, {27'b0, m_inst[24:20]});
    end
    m_live  = imem_rvalid && !m_stale;
    m_avail = m_buf || m_live;
    if (!rst) chk1("m_stall_IMEM", stall_IMEM, !m_avail);
    req_q  = imem_req;
    addr_q = imem_addr;
    pend_q = mem_pend;
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached CHECKS %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r;
    repeat (3) @(negedge clk);
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk1("rst_IFvalid", IFvalid, 1'b0);
    chk("rst_IFinst", IFinst, NOP_INST_WORD);
    chk("rst_IFpc", IFpc, 32'h0);
    chk1("rst_stall", stall_IMEM, 1'b1);
    #1 rst = 1'b0;

    // Zero-wait memory, HS_DN: requests in cycles 1, 3; first entry loaded after cycle 2.
    @(negedge clk);
    chk1("c1_req", imem_req, 1'b1);
    chk("c1_addr", imem_addr, 32'h100);
    @(negedge clk);
    chk1("c2_stall", stall_IMEM, 1'b0);
    @(negedge clk);
    chk1("c3_IFvalid", IFvalid, 1'b1);
    chk("c3_IFpc", IFpc, 32'h100);
    chk("c3_IFinst", IFinst, word_at(32'h100));
    chk("c3_addr", imem_addr, 32'h104);
    @(negedge clk);
    #1 hazard_signal = STALL_EARLY;

    // Response for 0x104 lands in the buffer.
    @(negedge clk);
    chk1("buf_req_low", imem_req, 1'b0);
    chk1("buf_stall", stall_IMEM, 1'b0);
    chk("buf_IFpc_held", IFpc, 32'h100);
    #1 hazard_signal = HS_DN;
    @(negedge clk);
    chk("buf_IFinst", IFinst, word_at(32'h104));
    chk("buf_IFpc", IFpc, 32'h104);
    chk("buf_next_addr", imem_addr, 32'h108);
    #1 lat = 3;

    // FLUSH_ALL while waiting for a slow response.
    @(negedge clk);
    chk1("fa_wait_stall", stall_IMEM, 1'b1);
    #1 begin hazard_signal = FLUSH_ALL; redirect_pc = 32'h200; end
    @(negedge clk);
    chk1("fa_IFvalid", IFvalid, 1'b0);
    chk("fa_IFinst", IFinst, NOP_INST_WORD);
    #1 hazard_signal = HS_DN;
    @(negedge clk);
    chk1("fa_stale_rsp", stall_IMEM, 1'b1);
    @(negedge clk);
    chk("fa_target", imem_addr, 32'h200);
    chk1("fa_target_req", imem_req, 1'b1);
    #1 begin lat = 1; imem_ready = 1'b0; end

    // FLUSH_EARLY while the request is held by imem_ready=0 for three edges.
    @(negedge clk);
    #1 begin hazard_signal = FLUSH_EARLY; jump_pc = 32'h300; end
    @(negedge clk);
    chk("fe_addr_held", imem_addr, 32'h200);
    #1 hazard_signal = HS_DN;
    @(negedge clk);
    chk("fe_addr_held2", imem_addr, 32'h200);
    #1 imem_ready = 1'b1;
    @(negedge clk);
    chk1("fe_stale_rsp", stall_IMEM, 1'b1);
    @(negedge clk);
    chk("fe_target", imem_addr, 32'h300);

    // Flush in the same cycle as a live response.
    @(negedge clk);
    chk1("fr_live", stall_IMEM, 1'b0);
    #1 begin hazard_signal = FLUSH_ALL; redirect_pc = 32'h400; end
    @(negedge clk);
    chk("fr_target", imem_addr, 32'h400);
    chk1("fr_req", imem_req, 1'b1);
    chk1("fr_IFvalid", IFvalid, 1'b0);
    #1 hazard_signal = HS_DN;
    @(negedge clk);
    @(negedge clk);
    chk("fr_IFpc", IFpc, 32'h400);

    // Wrap-around from 0xFFFF_FFFC.
    #1 begin hazard_signal = FLUSH_EARLY; jump_pc = 32'hFFFF_FFFC; end
    @(negedge clk);
    #1 hazard_signal = HS_DN;
    @(negedge clk);
    chk("wrap_first", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    @(negedge clk);
    chk("wrap_next", imem_addr, 32'h0000_0000);
    chk("wrap_IFpc", IFpc, 32'hFFFF_FFFC);

    // Randomized hazards, memory back-pressure and latency, with one mid-run reset.
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      #1;
      if (i == 1200) rst = 1'b1;
      else if (i == 1203) rst = 1'b0;
      r = $urandom_range(99);
      if (r < 68)      hazard_signal = HS_DN;
      else if (r < 78) hazard_signal = STALL_MMU;
      else if (r < 88) hazard_signal = STALL_EARLY;
      else if (r < 94) hazard_signal = FLUSH_ALL;
      else             hazard_signal = FLUSH_EARLY;
      redirect_pc = $urandom & 32'hFFFF_FFFC;
      jump_pc     = $urandom & 32'hFFFF_FFFC;
      imem_ready  = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) lat = int'($urandom_range(3, 1));
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage with its IF/ID pipeline register. It generates PCs and runs the IMEM request/response handshake, with at most one request outstanding and a one-entry response buffer. It presents the IF/ID register to decode and drives `stall_IMEM` into the hazard unit. It consumes `hazard_signal` to advance, hold or flush, and takes redirect targets for `FLUSH_ALL` (EX branch/PCSel) and `FLUSH_EARLY` (ID jump).

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INST`, default 32'h0000_0013: value loaded into `IFinst` on reset and on flush.

Ports:
- `clk` in 1: clock. The block has one clock domain.
- `rst` in 1: reset, synchronous and active-high.
- `hazard_signal` in 4: encoding from `inst_defs.v` (`FLUSH_ALL`, `FLUSH_EARLY`, `STALL_MMU`, `STALL_EARLY`, `HS_DN`).
- `redirect_pc` in 32: target used on `FLUSH_ALL`.
- `jump_pc` in 32: target used on `FLUSH_EARLY`.
- `imem_req` out 1: request valid; this is a registered output.
- `imem_addr` out 32: request address; this is a registered output.
- `imem_ready` in 1: request accepted when `imem_req && imem_ready`.
- `imem_rvalid` in 1: response valid. Memory returns exactly one response per accepted request, in order.
- `imem_rdata` in 32: instruction word.
- `stall_IMEM` out 1: no live instruction is available to enter IF/ID this cycle.
- `IFpc` out 32: IF/ID register, instruction PC.
- `IFinst` out 32: IF/ID register, instruction word.
- `IFvalid` out 1: IF/ID register, entry is valid.
- `IFrs1` out 5: combinational decode, `IFinst[19:15]`.
- `IFrs2` out 5: combinational decode, `IFinst[24:20]`.

## Operation
- The FSM has three states: IDLE (nothing outstanding), REQ (`imem_req`=1, waiting for ready), WAIT (accepted, waiting for rvalid).
- Additional state: `fetch_pc` (next address to request), `drop` (the outstanding request is stale), `buf_valid`/`buf_inst`/`buf_pc`.
- A "live response" is `imem_rvalid && !drop`.
- `advance` = (`hazard_signal == HS_DN`).
- `flush` = `FLUSH_ALL` or `FLUSH_EARLY`. The target is `redirect_pc` or `jump_pc` respectively.
- Flush actions:
  - `fetch_pc` <= target.
  - `buf_valid` <= 0.
  - `IFvalid` <= 0 and `IFinst` <= `NOP_INST`.
  - In REQ, or in WAIT without rvalid, set `drop` <= 1.
  - In WAIT with rvalid in the same cycle, discard the response, clear `drop`, and go to REQ.
  - In IDLE, go to REQ.
- IF/ID update on `advance`:
  - Load from the buffer if `buf_valid`; otherwise load from the live response (`IFpc` <= `imem_addr`).
  - Set `IFvalid` <= 1.
  - Stalls (`STALL_MMU`, `STALL_EARLY`) hold IF/ID unchanged.
- IDLE → REQ when `!buf_valid`, or when the buffer is consumed this cycle. On entry to REQ, latch `imem_addr` <= `fetch_pc`.
- REQ → WAIT on `imem_ready`:
  - If the request is not stale and there is no flush this cycle, `fetch_pc` <= `imem_addr` + 4.
  - If the request is stale, `fetch_pc` holds the target.
  - `imem_req` and `imem_addr` are never changed while `imem_req`=1 and not accepted, including during a flush.
- WAIT on rvalid:
  - If `drop` is set: clear `drop`, go to REQ.
  - If the response is live and `advance`: the response goes to IF/ID, go to REQ.
  - If the response is live and stalled: write it to the buffer, go to IDLE.
- `stall_IMEM` = `!buf_valid && !(live response)`. It is a function of state and IMEM inputs only, never of `hazard_signal`, so no combinational loop forms with the hazard unit.
- PC arithmetic is modulo 2^32. Wrap-around at 32'hFFFF_FFFC goes to 0, with no special handling.

## Timing
- Reset values:
  - State IDLE; `fetch_pc`=`RESET_PC`; `drop`=0; `buf_valid`=0.
  - `imem_req`=0, `imem_addr`=0.
  - `IFvalid`=0, `IFinst`=`NOP_INST`, `IFpc`=0.
  - `stall_IMEM`=1.
- Reset mid-transaction: the outstanding request is abandoned. The memory is reset by the same `rst`.
- Timing from reset release:
  - First `imem_req` is high in cycle 1 after reset release.
  - Response is consumed into IF/ID at the edge of the rvalid cycle.
- Peak throughput with a zero-wait-state memory is 1 instruction per 2 cycles (REQ cycle, then WAIT/rvalid cycle).
- Flush-to-request latency: the target appears on `imem_addr` 1 cycle after the flush if in IDLE or WAIT+rvalid. Otherwise it appears after the stale response retires.
- Flush has priority over every other event in the same cycle.

## Structure
- The `hazard_signal` encodings come from the shared `inst_defs.v`.
- Add `NOP_INST` and the FSM state encodings there.
- The one-entry response buffer is a natural sub-module, `fetch_buffer` (write, read, clear, valid).

## Test plan
- Reset with `RESET_PC`=0x100, single-cycle memory, `HS_DN` throughout: request addresses 0x100, 0x104, 0x108 in cycles 1, 3, 5; `IFvalid`=1 with `IFpc`=0x100 after cycle 2.
- `STALL_EARLY` during the rvalid cycle for 0x104: response is buffered, `imem_req` stays low, and `stall_IMEM`=0. On the following `HS_DN`, `IFinst` takes the buffered word.
- `FLUSH_ALL` with `redirect_pc`=0x200 while in WAIT (no rvalid): the next response is discarded, `IFvalid`=0, and the next request address is 0x200.
- `FLUSH_EARLY` with `jump_pc`=0x300 while `imem_req` is held because `imem_ready`=0 for 3 cycles: `imem_addr` is unchanged until accepted, the response is dropped, and the next request is 0x300.
- Flush in the same cycle as rvalid: the word never reaches IF/ID, and the request for the target issues the next cycle.
- With `fetch_pc`=0xFFFF_FFFC and `HS_DN`, the next request address is 0x0000_0000.
